// File: rtl/sbox_cfg_pkg.sv
// Shared definitions for the switch-box configuration controller:
// matrix geometry, side and error encodings, FSM states and the
// entry-index to (side, pin) mapping used by the word checker.
package sbox_cfg_pkg;

    localparam int NTOP  = 5;
    localparam int NSIDE = 4;
    localparam int CFG_W = 6;
    localparam int N_ENT = 2 * NTOP + 2 * NSIDE;
    localparam int ACT_W = N_ENT * CFG_W;

    // Side codes carried in cfg word bits [2:0]
    localparam logic [2:0] SIDE_NONE   = 3'd0;
    localparam logic [2:0] SIDE_TOP    = 3'd1;
    localparam logic [2:0] SIDE_RIGHT  = 3'd2;
    localparam logic [2:0] SIDE_BOTTOM = 3'd3;
    localparam logic [2:0] SIDE_LEFT   = 3'd4;

    // Error codes reported on err_code
    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_SIDE  = 2'd1;
    localparam logic [1:0] ERR_INDEX = 2'd2;
    localparam logic [1:0] ERR_FRAME = 2'd3;

    // Sized limits so comparisons stay width-matched
    localparam logic [2:0] NTOP_LIM   = 3'(NTOP);
    localparam logic [2:0] NSIDE_LIM  = 3'(NSIDE);
    localparam logic [4:0] ENT_LAST   = 5'(N_ENT - 1);
    localparam logic [4:0] BOT_BASE   = 5'(NTOP);
    localparam logic [4:0] LEFT_BASE  = 5'(2 * NTOP);
    localparam logic [4:0] RIGHT_BASE = 5'(2 * NTOP + NSIDE);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_ERROR  = 2'd3
    } state_t;

    typedef struct packed {
        logic [2:0] side;
        logic [2:0] pin;
    } ent_loc_t;

    // Entry order: top[0..4], bottom[0..4], left[0..3], right[0..3]
    function automatic ent_loc_t ent_to_loc(input logic [4:0] ent);
        ent_loc_t   loc;
        logic [4:0] off;
        if (ent < BOT_BASE) begin
            loc.side = SIDE_TOP;
            off      = ent;
        end else if (ent < LEFT_BASE) begin
            loc.side = SIDE_BOTTOM;
            off      = ent - BOT_BASE;
        end else if (ent < RIGHT_BASE) begin
            loc.side = SIDE_LEFT;
            off      = ent - LEFT_BASE;
        end else begin
            loc.side = SIDE_RIGHT;
            off      = ent - RIGHT_BASE;
        end
        loc.pin = off[2:0];
        return loc;
    endfunction

endpackage

// File: rtl/sbox_cfg_check.sv
// Combinational validator for one routing word: geometry (side code,
// pin index, self-loop) and frame-length checks, prioritised
// side > index/self-loop > framing.
module sbox_cfg_check
    import sbox_cfg_pkg::*;
(
    input  logic [CFG_W-1:0] word,
    input  logic [4:0]       entry,
    input  logic             last,
    input  logic [4:0]       count,
    output logic [1:0]       err_code
);

    logic [2:0] side_s;
    logic [2:0] idx_s;
    ent_loc_t   loc_s;
    logic       bad_side_s;
    logic       bad_idx_s;
    logic       self_s;
    logic       bad_frame_s;

    // Decode the word and classify it against the entry it will occupy
    always_comb begin
        side_s     = word[2:0];
        idx_s      = word[5:3];
        loc_s      = ent_to_loc(entry);
        bad_side_s = (side_s > SIDE_LEFT);
        bad_idx_s  = 1'b0;
        case (side_s)
            SIDE_TOP, SIDE_BOTTOM: bad_idx_s = (idx_s >= NTOP_LIM);
            SIDE_RIGHT, SIDE_LEFT: bad_idx_s = (idx_s >= NSIDE_LIM);
            default:               bad_idx_s = 1'b0;
        endcase
        // A floating pin (side none) can never loop back onto itself
        self_s      = (side_s != SIDE_NONE) && (side_s == loc_s.side) &&
                      (idx_s == loc_s.pin);
        bad_frame_s = (last && (count < ENT_LAST)) ||
                      (!last && (count == ENT_LAST));
        if (bad_side_s) begin
            err_code = ERR_SIDE;
        end else if (bad_idx_s || self_s) begin
            err_code = ERR_INDEX;
        end else if (bad_frame_s) begin
            err_code = ERR_FRAME;
        end else begin
            err_code = ERR_NONE;
        end
    end

endmodule

// File: rtl/sbox_cfg_ctrl.sv
// Switch-box configuration controller. Streams 18 routing words into a
// shadow store, validates each one, and commits a clean frame to the
// active configuration bus in a single cycle.
// Optional readback port enabled by defining SBOX_CFG_READBACK_EN.
module sbox_cfg_ctrl
    import sbox_cfg_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CFG_W-1:0] cfg_data,
    input  logic             cfg_last,
    output logic [ACT_W-1:0] cfg_active,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code
`ifdef SBOX_CFG_READBACK_EN
    ,
    input  logic [4:0]       rb_addr,
    output logic [CFG_W-1:0] rb_data
`endif
);

    state_t           state_r;
    logic [4:0]       count_r;
    logic             last_seen_r;
    logic [CFG_W-1:0] shadow_r [N_ENT];
    logic [ACT_W-1:0] shadow_flat_s;
    logic [1:0]       chk_code_s;
    logic             hs_s;

    assign hs_s = cfg_valid & cfg_ready;

    sbox_cfg_check u_check (
        .word     (cfg_data),
        .entry    (count_r),
        .last     (cfg_last),
        .count    (count_r),
        .err_code (chk_code_s)
    );

    // Flatten the shadow store into the active-bus layout
    always_comb begin
        shadow_flat_s = {ACT_W{1'b0}};
        for (int e = 0; e < N_ENT; e++) begin
            shadow_flat_s[e*CFG_W +: CFG_W] = shadow_r[e];
        end
    end

    // Frame-load FSM with registered handshake, status and active bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            count_r     <= 5'd0;
            last_seen_r <= 1'b0;
            cfg_active  <= {ACT_W{1'b0}};
            cfg_ready   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            err_code    <= ERR_NONE;
            for (int e = 0; e < N_ENT; e++) begin
                shadow_r[e] <= {CFG_W{1'b0}};
            end
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE, ST_ERROR: begin
                    // start is only honoured when no frame is in flight
                    if (start) begin
                        state_r     <= ST_LOAD;
                        count_r     <= 5'd0;
                        last_seen_r <= 1'b0;
                        err         <= 1'b0;
                        err_code    <= ERR_NONE;
                        cfg_ready   <= 1'b1;
                        busy        <= 1'b1;
                        for (int e = 0; e < N_ENT; e++) begin
                            shadow_r[e] <= {CFG_W{1'b0}};
                        end
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        state_r     <= ST_IDLE;
                        last_seen_r <= 1'b0;
                        cfg_ready   <= 1'b0;
                        busy        <= 1'b0;
                    end else if (hs_s) begin
                        if (chk_code_s != ERR_NONE) begin
                            state_r   <= ST_ERROR;
                            err       <= 1'b1;
                            err_code  <= chk_code_s;
                            cfg_ready <= 1'b0;
                            busy      <= 1'b0;
                        end else begin
                            shadow_r[count_r] <= cfg_data;
                            count_r           <= count_r + 5'd1;
                            // Final word accepted: close the port, commit next
                            if (cfg_last) begin
                                cfg_ready   <= 1'b0;
                                last_seen_r <= 1'b1;
                            end
                        end
                    end else if (last_seen_r) begin
                        state_r     <= ST_COMMIT;
                        last_seen_r <= 1'b0;
                    end
                end
                ST_COMMIT: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    if (!abort) begin
                        cfg_active <= shadow_flat_s;
                        done       <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    last_seen_r <= 1'b0;
                    cfg_ready   <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

`ifdef SBOX_CFG_READBACK_EN
    logic [CFG_W-1:0] rb_sel_s;

    // Select the addressed committed entry; out-of-range reads zero
    always_comb begin
        rb_sel_s = {CFG_W{1'b0}};
        for (int e = 0; e < N_ENT; e++) begin
            if (rb_addr == 5'(e)) begin
                rb_sel_s = cfg_active[e*CFG_W +: CFG_W];
            end else begin
                rb_sel_s = rb_sel_s;
            end
        end
    end

    // Register the readback value for one-cycle latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rb_data <= {CFG_W{1'b0}};
        end else begin
            rb_data <= rb_sel_s;
        end
    end
`endif

endmodule

// File: tb/tb_sbox_cfg_ctrl.sv
// Scoreboard bench for sbox_cfg_ctrl: stimulus pushes the expected
// commit/error event, a negedge monitor pops and compares it.
module tb_sbox_cfg_ctrl;
    import sbox_cfg_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             cfg_valid = 1'b0;
    logic             cfg_last = 1'b0;
    logic [CFG_W-1:0] cfg_data = '0;
    logic             cfg_ready;
    logic [ACT_W-1:0] cfg_active;
    logic             busy, done, err;
    logic [1:0]       err_code;
`ifdef SBOX_CFG_READBACK_EN
    logic [4:0]       rb_addr = '0;
    logic [CFG_W-1:0] rb_data;
`endif

    sbox_cfg_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_data   (cfg_data),
        .cfg_last   (cfg_last),
        .cfg_active (cfg_active),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code)
`ifdef SBOX_CFG_READBACK_EN
        ,
        .rb_addr    (rb_addr),
        .rb_data    (rb_data)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             is_err;
        logic [1:0]       code;
        logic [ACT_W-1:0] active;
    } exp_t;

    exp_t             exp_q[$];
    int               checks = 0;
    int               errors = 0;
    int               cyc = 0;
    int               last_hs = 0;
    logic             err_q = 1'b0;
    logic [ACT_W-1:0] frame_a, frame_b;

    task automatic chk(input string name, input logic [ACT_W-1:0] act, input logic [ACT_W-1:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic expect_out(input logic is_err, input logic [1:0] code, input logic [ACT_W-1:0] act);
        exp_t e;
        e.is_err = is_err;
        e.code   = code;
        e.active = act;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_frame();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_word(input logic [CFG_W-1:0] d, input logic l, input logic ab);
        bit got = 0;
        cfg_data  = d;
        cfg_last  = l;
        cfg_valid = 1'b1;
        abort     = ab;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (cfg_ready) got = 1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: got cfg_ready=0 expected 1 within 50 cycles");
        end else begin
            @(posedge clk);
        end
        #1;
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        abort     = 1'b0;
        start     = 1'b0;
    endtask

    task automatic send_zeros(input int n);
        for (int i = 0; i < n; i++) send_word(6'b000000, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input logic [ACT_W-1:0] f, input int max_gap,
                              input int abort_at, input int restart_at);
        for (int e = 0; e < N_ENT; e++) begin
            if (max_gap > 0) idle($urandom_range(0, max_gap));
            if (e == restart_at) start = 1'b1;
            send_word(f[e*CFG_W +: CFG_W], e == N_ENT - 1, e == abort_at);
            if (e == abort_at) return;
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        chk({"pending_", name}, ACT_W'(exp_q.size()), ACT_W'(0));
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: pops one expectation per done pulse or rising err
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
            err_q = 1'b0;
        end else begin
            if (cfg_valid && cfg_ready && cfg_last && !abort) last_hs = cyc + 1;
            if (done || (err && !err_q)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got done=%0b err=%0b expected none", done, err);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind", ACT_W'({done, err}), ACT_W'(e.is_err ? 2'b01 : 2'b10));
                    chk("err_code", ACT_W'(err_code), ACT_W'(e.code));
                    chk("cfg_active", cfg_active, e.active);
                    if (done) chk("done_latency", ACT_W'(cyc - last_hs), ACT_W'(2));
                    if (err) chk("ready_after_err", ACT_W'(cfg_ready), ACT_W'(0));
                end
            end
            err_q = err;
        end
    end

    initial begin
        frame_a = '0;
        frame_a[0*CFG_W +: CFG_W]  = 6'b000_010;
        frame_a[5*CFG_W +: CFG_W]  = 6'b001_001;
        frame_a[10*CFG_W +: CFG_W] = 6'b011_010;
        frame_a[12*CFG_W +: CFG_W] = 6'b100_011;
        frame_a[17*CFG_W +: CFG_W] = 6'b011_100;
        frame_b = '0;
        frame_b[0*CFG_W +: CFG_W]  = 6'b100_011;
        frame_b[3*CFG_W +: CFG_W]  = 6'b001_100;
        frame_b[9*CFG_W +: CFG_W]  = 6'b000_100;
        frame_b[14*CFG_W +: CFG_W] = 6'b010_001;

        // Reset state
        #12;
        chk("rst_active", cfg_active, '0);
        chk("rst_ready", ACT_W'(cfg_ready), ACT_W'(0));
        chk("rst_busy", ACT_W'(busy), ACT_W'(0));
        chk("rst_done", ACT_W'(done), ACT_W'(0));
        chk("rst_err", ACT_W'({err, err_code}), ACT_W'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // Legal frame A
        expect_out(1'b0, ERR_NONE, frame_a);
        start_frame();
        chk("load_busy", ACT_W'({busy, cfg_ready}), ACT_W'(2'b11));
        send_frame(frame_a, 0, -1, -1);
        wait_drain("frame_a");
        idle(1);
        chk("idle_after_commit", ACT_W'({busy, cfg_ready, done}), ACT_W'(0));
        chk("entry0", ACT_W'(cfg_active[5:0]), ACT_W'(6'b000010));

        // Bad side code on word 3
        expect_out(1'b1, ERR_SIDE, frame_a);
        start_frame();
        send_zeros(2);
        send_word(6'b000_101, 1'b0, 1'b0);
        wait_drain("bad_side");

        // Self-loop on top[0]
        expect_out(1'b1, ERR_INDEX, frame_a);
        start_frame();
        send_word(6'b000_001, 1'b0, 1'b0);
        wait_drain("self_loop");

        // right[4] does not exist
        expect_out(1'b1, ERR_INDEX, frame_a);
        start_frame();
        send_zeros(10);
        send_word(6'b100_010, 1'b0, 1'b0);
        wait_drain("bad_index");

        // Early last on word 5
        expect_out(1'b1, ERR_FRAME, frame_a);
        start_frame();
        send_zeros(4);
        send_word(6'b000_000, 1'b1, 1'b0);
        wait_drain("early_last");

        // Missing last on word 18
        expect_out(1'b1, ERR_FRAME, frame_a);
        start_frame();
        send_zeros(18);
        wait_drain("missing_last");

        // Priority: side beats framing, index beats framing
        expect_out(1'b1, ERR_SIDE, frame_a);
        start_frame();
        send_word(6'b000_111, 1'b1, 1'b0);
        wait_drain("prio_side");
        expect_out(1'b1, ERR_INDEX, frame_a);
        start_frame();
        send_word(6'b101_001, 1'b1, 1'b0);
        wait_drain("prio_index");
        idle(3);
        chk("err_sticky", ACT_W'({err, err_code}), ACT_W'({1'b1, ERR_INDEX}));

        // Abort at word 9 with random gaps: no output, active unchanged
        start_frame();
        send_frame(frame_b, 2, 8, -1);
        idle(4);
        chk("abort_idle", ACT_W'({busy, cfg_ready, err}), ACT_W'(0));
        chk("abort_active", cfg_active, frame_a);

        // Full frame B with a stray start mid-load
        expect_out(1'b0, ERR_NONE, frame_b);
        start_frame();
        send_frame(frame_b, 1, -1, 6);
        wait_drain("frame_b");
        idle(1);
        chk("frame_b_active", cfg_active, frame_b);

`ifdef SBOX_CFG_READBACK_EN
        rb_addr = 5'd0;
        idle(1);
        chk("rb_entry0", ACT_W'(rb_data), ACT_W'(6'b100_011));
        rb_addr = 5'd3;
        idle(1);
        chk("rb_entry3", ACT_W'(rb_data), ACT_W'(6'b001_100));
        rb_addr = 5'd20;
        idle(1);
        chk("rb_out_of_range", ACT_W'(rb_data), ACT_W'(0));
`endif

        // Asynchronous reset mid-load
        start_frame();
        send_zeros(3);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_active", cfg_active, '0);
        chk("midrst_flags", ACT_W'({err, busy, cfg_ready}), ACT_W'(0));
        exp_q.delete();
        idle(2);
        rst_n = 1'b1;
        idle(2);
        chk("post_rst_idle", ACT_W'({busy, done, err}), ACT_W'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
